cic_interp_ctrl: RTL and testbench
==================================

// Module: cic_interp_ctrl
// PURPOSE
//  Sequencer for the CIC interpolator in the DUC chain. Derives strobe_in/strobe_out/enable
//  for the CIC from a DAC-rate output tick and the programmed interpolation rate. Pulls input
//  samples from an upstream valid/ready source into a holding register that feeds signal_in.
//  Makes rate changes safe by flushing the CIC (enable low), then re-priming it.
// PARAMETERS
//  BW        16   sample width (matches CIC bw)
//  MAX_RATE  128  largest legal rate; must equal 2**log2_of_max_rate of the CIC
//  FLUSH_LEN 2    cycles cic_enable is held low on start/rate change (>=1)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high
//  run           in   1   level; 1 = interpolate, 0 = stop and hold CIC cleared
//  rate_in       in   8   requested interpolation rate
//  rate_set      in   1   pulse; latch rate_in and restart via FLUSH
//  out_tick      in   1   one pulse per output (DAC-rate) sample
//  in_tdata      in   BW  upstream sample
//  in_tvalid     in   1   upstream sample available
//  in_tready     out  1   pop strobe to upstream (transfer when in_tvalid & in_tready)
//  cic_enable    out  1   to CIC enable
//  cic_strobe_in out  1   to CIC strobe_in
//  cic_strobe_out out 1   to CIC strobe_out
//  cic_rate      out  8   to CIC rate (effective, clamped)
//  cic_data      out  BW  to CIC signal_in (holding register)
//  underrun      out  1   sticky; sample due while in_tvalid=0
//  clear_status  in   1   pulse; clears underrun
// BEHAVIOUR
//  Reset values: state=IDLE; all outputs 0; cic_rate=1; phase=0; internal tick_d=0.
//  Rate rule: effective rate = 1 if rate_in<=1; MAX_RATE if rate_in>MAX_RATE; else rate_in.
//   Latched into cic_rate only on rate_set (any state) or on IDLE->FLUSH.
//  Phase counter 0..rate-1: advances on out_tick in RUN; wraps rate-1 -> 0; forced 0 outside RUN.
//  States:
//   IDLE : cic_enable=0. run=1 -> FLUSH (load flush count).
//   FLUSH: cic_enable=0 for FLUSH_LEN cycles, then -> PRIME. run=0 -> IDLE.
//   PRIME: cic_enable=1, no strobes. in_tvalid=1 -> RUN, phase=0. run=0 -> IDLE.
//   RUN  : cic_enable=1. run=0 -> IDLE. rate_set -> FLUSH (priority over run=1).
//  Pop: in RUN, out_tick & phase==0 -> in_tready=1 (combinational, same cycle).
//   If in_tvalid: cic_data<=in_tdata. Else: cic_data<=0, underrun<=1.
//  CIC strobes, one cycle after out_tick (registered tick_d, gated by state==RUN in the
//   tick cycle): cic_strobe_out=tick_d; cic_strobe_in=tick_d & (phase was 0).
//   Latency: upstream pop -> cic_strobe_in = 1 cycle; cic_data stable from that cycle.
//  Rate 1: every out_tick pops and issues strobe_in together with strobe_out.
//  Simultaneous: rate_set and out_tick in RUN -> no pop and no strobes for that tick.
//   clear_status with a new underrun -> underrun stays 1 (set wins).
//  Async reset mid-RUN: everything returns to IDLE values immediately. No partial strobe.
//  out_tick outside RUN is ignored and no sample is consumed.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/FLUSH/PRIME/RUN) and the rate-clamp
//   function, so the decimator controller can reuse them.
//  One sub-module, cic_rate_phase: latched rate + phase counter + wrap detect.
//  FSM, pop logic and strobe pipeline stay in the top level.
// TESTING
//  1. rate_set rate_in=4, run=1, in_tvalid=1, out_tick every cycle -> FLUSH 2 cycles
//     (enable=0), PRIME 1 cycle, then cic_strobe_in on every 4th strobe_out, pops = ticks/4.
//  2. rate_in=0 and rate_in=1 -> cic_rate=1, strobe_in==strobe_out every tick;
//     rate_in=200 -> cic_rate=128.
//  3. RUN, rate 8, drop in_tvalid at a phase-0 tick -> cic_data=0, underrun=1 and held;
//     clear_status -> 0.
//  4. rate_set rate_in=2 mid-RUN at rate 16 -> enable low FLUSH_LEN cycles, phase=0,
//     new pops every 2 ticks.
//  5. Assert reset asynchronously between ticks in RUN -> all outputs 0, cic_rate=1 at once.
//  6. run=0 during PRIME and during RUN -> IDLE next cycle, cic_enable=0, no further pops.

Source files
------------

// File: rtl/cic_interp_ctrl_pkg.sv
// Shared definitions for the CIC interpolator/decimator controllers:
// sequencer state encoding, rate width and the rate-clamp rule.
package cic_interp_ctrl_pkg;

    localparam int RATE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_PRIME = 2'd2,
        ST_RUN   = 2'd3
    } ctrl_state_t;

    // Requested rates of 0/1 both mean "no interpolation"; anything past the
    // CIC's maximum is pinned to that maximum.
    function automatic logic [RATE_W-1:0] clamp_rate(
        input logic [RATE_W-1:0] req,
        input logic [RATE_W-1:0] max_rate
    );
        if (req <= RATE_W'(1))
            return RATE_W'(1);
        else if (req > max_rate)
            return max_rate;
        else
            return req;
    endfunction

endpackage

// File: rtl/cic_rate_phase.sv
// Latched (clamped) interpolation rate and the output-sample phase counter
// that decides which output ticks pull a new input sample.
module cic_rate_phase
    import cic_interp_ctrl_pkg::*;
#(
    parameter int MAX_RATE = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rate_load,
    input  logic [RATE_W-1:0] rate_in,
    input  logic              advance,
    input  logic              clear,
    output logic [RATE_W-1:0] rate,
    output logic [RATE_W-1:0] phase,
    output logic              phase_zero
);

    logic wrap;

    // Phase has reached the last output of the current input sample.
    assign wrap       = (phase >= rate - RATE_W'(1));
    assign phase_zero = (phase == '0);

    // Latch the effective rate when the controller asks for it.
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rate <= RATE_W'(1);
        else if (rate_load)
            rate <= clamp_rate(rate_in, RATE_W'(MAX_RATE));
    end

    // Count output ticks modulo rate; held at zero whenever not running.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            phase <= '0;
        else if (clear)
            phase <= '0;
        else if (advance)
            phase <= wrap ? '0 : phase + RATE_W'(1);
    end

endmodule

// File: rtl/cic_interp_ctrl.sv
// Sequencer for the DUC CIC interpolator: flush/prime/run state machine,
// upstream sample pop into the CIC input holding register, and the
// one-cycle-delayed strobe pipeline driving the CIC.
module cic_interp_ctrl
    import cic_interp_ctrl_pkg::*;
#(
    parameter int BW        = 16,
    parameter int MAX_RATE  = 128,
    parameter int FLUSH_LEN = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [RATE_W-1:0] rate_in,
    input  logic              rate_set,
    input  logic              out_tick,
    input  logic [BW-1:0]     in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic              cic_enable,
    output logic              cic_strobe_in,
    output logic              cic_strobe_out,
    output logic [RATE_W-1:0] cic_rate,
    output logic [BW-1:0]     cic_data,
    output logic              underrun,
    input  logic              clear_status
);

    localparam int FLUSH_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_LEN - 1);

    ctrl_state_t       state;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [RATE_W-1:0] phase;
    logic              phase_zero;
    logic              tick_ok;
    logic              pop;
    logic              tick_d;
    logic              pop_d;

    // A tick is honoured only in RUN and never together with a rate change.
    assign tick_ok = (state == ST_RUN) && out_tick && !rate_set;
    assign pop     = tick_ok && phase_zero;

    // NOTE: in_tready is deliberately combinational so the upstream pop
    // lands in the same cycle as the tick that calls for it.
    assign in_tready      = pop;
    assign cic_strobe_out = tick_d;
    assign cic_strobe_in  = pop_d;

    cic_rate_phase #(
        .MAX_RATE (MAX_RATE)
    ) u_rate_phase (
        .clock      (clock),
        .reset      (reset),
        .rate_load  (rate_set || ((state == ST_IDLE) && run)),
        .rate_in    (rate_in),
        .advance    (tick_ok),
        .clear      ((state != ST_RUN) || rate_set),
        .rate       (cic_rate),
        .phase      (phase),
        .phase_zero (phase_zero)
    );

    // Sequencer: flush the CIC with enable low, prime it, then run.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            cic_enable <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state     <= ST_FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (!run) begin
                        state <= ST_IDLE;
                    end else if (rate_set) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt == '0) begin
                        state      <= ST_PRIME;
                        cic_enable <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - FLUSH_W'(1);
                    end
                end
                ST_PRIME: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        cic_enable <= 1'b0;
                    end else if (rate_set) begin
                        state      <= ST_FLUSH;
                        flush_cnt  <= FLUSH_LOAD;
                        cic_enable <= 1'b0;
                    end else if (in_tvalid) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state      <= ST_IDLE;
                        cic_enable <= 1'b0;
                    end else if (rate_set) begin
                        state      <= ST_FLUSH;
                        flush_cnt  <= FLUSH_LOAD;
                        cic_enable <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cic_enable <= 1'b0;
                end
            endcase
        end
    end

    // Strobe pipeline, holding register and sticky underrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_d   <= 1'b0;
            pop_d    <= 1'b0;
            cic_data <= '0;
            underrun <= 1'b0;
        end else begin
            tick_d <= tick_ok;
            pop_d  <= pop;
            if (pop)
                cic_data <= in_tvalid ? in_tdata : '0;
            // A fresh underrun outranks a simultaneous clear.
            if (pop && !in_tvalid)
                underrun <= 1'b1;
            else if (clear_status)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_interp_ctrl.sv
// Directed bench for cic_interp_ctrl (BW=16, MAX_RATE=128, FLUSH_LEN=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// before the next edge.
module tb_cic_interp_ctrl;

    localparam int BW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic [7:0]    rate_in = '0;
    logic          rate_set = 1'b0;
    logic          out_tick = 1'b0;
    logic [BW-1:0] in_tdata = '0;
    logic          in_tvalid = 1'b0;
    logic          in_tready;
    logic          cic_enable;
    logic          cic_strobe_in;
    logic          cic_strobe_out;
    logic [7:0]    cic_rate;
    logic [BW-1:0] cic_data;
    logic          underrun;
    logic          clear_status = 1'b0;

    int   n_cmp = 0;
    int   n_err = 0;
    logic last_ready;

    cic_interp_ctrl #(
        .BW        (BW),
        .MAX_RATE  (128),
        .FLUSH_LEN (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .rate_in        (rate_in),
        .rate_set       (rate_set),
        .out_tick       (out_tick),
        .in_tdata       (in_tdata),
        .in_tvalid      (in_tvalid),
        .in_tready      (in_tready),
        .cic_enable     (cic_enable),
        .cic_strobe_in  (cic_strobe_in),
        .cic_strobe_out (cic_strobe_out),
        .cic_rate       (cic_rate),
        .cic_data       (cic_data),
        .underrun       (underrun),
        .clear_status   (clear_status)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // One out_tick cycle; in_tready is captured just before the edge.
    task automatic tick(input logic valid, input logic [BW-1:0] data);
        out_tick  = 1'b1;
        in_tvalid = valid;
        in_tdata  = data;
        #1;
        last_ready = in_tready;
        cyc();
        out_tick = 1'b0;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        run          = 1'b0;
        rate_set     = 1'b0;
        out_tick     = 1'b0;
        in_tvalid    = 1'b0;
        clear_status = 1'b0;
        rate_in      = '0;
        in_tdata     = '0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // Program a rate and walk IDLE->FLUSH(2)->PRIME(1)->RUN with data available.
    task automatic start_run(input logic [7:0] rate);
        rate_in   = rate;
        rate_set  = 1'b1;
        run       = 1'b1;
        in_tvalid = 1'b1;
        out_tick  = 1'b0;
        cyc();
        rate_set = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if ({cic_enable, cic_strobe_in, cic_strobe_out, in_tready, underrun} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {cic_enable, cic_strobe_in, cic_strobe_out, in_tready, underrun}); end
        n_cmp++; if (cic_rate !== 8'd1) begin n_err++; $display("FAIL reset_rate: got %0d want 1", cic_rate); end
        n_cmp++; if (cic_data !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h want 0000", cic_data); end
        reset = 1'b0;
        cyc();
        n_cmp++; if (cic_enable !== 1'b0) begin n_err++; $display("FAIL reset_idle_enable: got %b want 0", cic_enable); end
    endtask

    task automatic test_rate4_stream();
        int pops;
        pops = 0;
        apply_reset();
        rate_in   = 8'd4;
        rate_set  = 1'b1;
        run       = 1'b1;
        in_tvalid = 1'b1;
        out_tick  = 1'b1;
        in_tdata  = 16'hAAAA;
        cyc();
        rate_set = 1'b0;
        #1;
        n_cmp++; if ({cic_enable, in_tready} !== 2'b00) begin n_err++; $display("FAIL r4_flush1: got en/rdy %b want 00", {cic_enable, in_tready}); end
        n_cmp++; if (cic_rate !== 8'd4) begin n_err++; $display("FAIL r4_rate: got %0d want 4", cic_rate); end
        cyc();
        n_cmp++; if ({cic_enable, in_tready} !== 2'b00) begin n_err++; $display("FAIL r4_flush2: got en/rdy %b want 00", {cic_enable, in_tready}); end
        cyc();
        n_cmp++; if ({cic_enable, in_tready, cic_strobe_out} !== 3'b100) begin n_err++; $display("FAIL r4_prime: got en/rdy/so %b want 100", {cic_enable, in_tready, cic_strobe_out}); end
        cyc();
        n_cmp++; if ({cic_enable, cic_strobe_out} !== 2'b10) begin n_err++; $display("FAIL r4_run_entry: got en/so %b want 10", {cic_enable, cic_strobe_out}); end
        for (int i = 0; i < 16; i++) begin
            in_tdata = 16'h0100 + 16'(i);
            #1;
            n_cmp++; if (in_tready !== ((i % 4) == 0)) begin n_err++; $display("FAIL r4_ready[%0d]: got %b want %b", i, in_tready, (i % 4) == 0); end
            if (in_tready === 1'b1) pops++;
            cyc();
            n_cmp++; if ({cic_strobe_out, cic_strobe_in} !== {1'b1, (i % 4) == 0}) begin n_err++; $display("FAIL r4_strobes[%0d]: got so/si %b want %b", i, {cic_strobe_out, cic_strobe_in}, {1'b1, (i % 4) == 0}); end
            if ((i % 4) == 0) begin
                n_cmp++; if (cic_data !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL r4_data[%0d]: got %h want %h", i, cic_data, 16'h0100 + 16'(i)); end
            end
        end
        out_tick = 1'b0;
        n_cmp++; if (pops !== 4) begin n_err++; $display("FAIL r4_pop_count: got %0d want 4", pops); end
    endtask

    task automatic test_rate_clamp();
        logic [7:0] req [7];
        logic [7:0] exp [7];
        req = '{8'd0, 8'd1, 8'd2, 8'd128, 8'd129, 8'd200, 8'd255};
        exp = '{8'd1, 8'd1, 8'd2, 8'd128, 8'd128, 8'd128, 8'd128};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            rate_in  = req[i];
            rate_set = 1'b1;
            cyc();
            rate_set = 1'b0;
            n_cmp++; if (cic_rate !== exp[i]) begin n_err++; $display("FAIL clamp[%0d]: rate_in %0d got %0d want %0d", i, req[i], cic_rate, exp[i]); end
        end
        n_cmp++; if (cic_enable !== 1'b0) begin n_err++; $display("FAIL clamp_idle: got enable %b want 0", cic_enable); end
        start_run(8'd0);
        n_cmp++; if (cic_rate !== 8'd1) begin n_err++; $display("FAIL rate1_latched: got %0d want 1", cic_rate); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 16'h0200 + 16'(i));
            n_cmp++; if ({last_ready, cic_strobe_in, cic_strobe_out} !== 3'b111) begin n_err++; $display("FAIL rate1_tick[%0d]: got rdy/si/so %b want 111", i, {last_ready, cic_strobe_in, cic_strobe_out}); end
            n_cmp++; if (cic_data !== 16'h0200 + 16'(i)) begin n_err++; $display("FAIL rate1_data[%0d]: got %h want %h", i, cic_data, 16'h0200 + 16'(i)); end
        end
    endtask

    task automatic test_underrun();
        apply_reset();
        start_run(8'd8);
        tick(1'b1, 16'h0301);
        n_cmp++; if ({last_ready, underrun} !== 2'b10) begin n_err++; $display("FAIL ur_first: got rdy/ur %b want 10", {last_ready, underrun}); end
        n_cmp++; if (cic_data !== 16'h0301) begin n_err++; $display("FAIL ur_first_data: got %h want 0301", cic_data); end
        for (int i = 1; i < 8; i++) begin
            tick(1'b1, 16'h0302);
            n_cmp++; if (last_ready !== 1'b0) begin n_err++; $display("FAIL ur_gap[%0d]: got ready %b want 0", i, last_ready); end
        end
        tick(1'b0, 16'h0BAD);
        n_cmp++; if ({last_ready, cic_strobe_in, underrun} !== 3'b111) begin n_err++; $display("FAIL ur_set: got rdy/si/ur %b want 111", {last_ready, cic_strobe_in, underrun}); end
        n_cmp++; if (cic_data !== 16'h0000) begin n_err++; $display("FAIL ur_data: got %h want 0000", cic_data); end
        repeat (3) cyc();
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_sticky: got %b want 1", underrun); end
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL ur_clear: got %b want 0", underrun); end
        for (int i = 1; i < 8; i++) tick(1'b1, 16'h0303);
        clear_status = 1'b1;
        tick(1'b0, 16'h0BAD);
        clear_status = 1'b0;
        n_cmp++; if ({last_ready, underrun} !== 2'b11) begin n_err++; $display("FAIL ur_set_wins: got rdy/ur %b want 11", {last_ready, underrun}); end
    endtask

    task automatic test_rate_change();
        apply_reset();
        start_run(8'd16);
        tick(1'b1, 16'h0401);
        n_cmp++; if (last_ready !== 1'b1) begin n_err++; $display("FAIL rc_first: got ready %b want 1", last_ready); end
        repeat (4) tick(1'b1, 16'h0402);
        rate_in   = 8'd2;
        rate_set  = 1'b1;
        out_tick  = 1'b1;
        in_tvalid = 1'b1;
        #1;
        n_cmp++; if (in_tready !== 1'b0) begin n_err++; $display("FAIL rc_no_pop: got ready %b want 0", in_tready); end
        cyc();
        rate_set = 1'b0;
        out_tick = 1'b0;
        n_cmp++; if ({cic_enable, cic_strobe_in, cic_strobe_out} !== 3'b000) begin n_err++; $display("FAIL rc_flush1: got en/si/so %b want 000", {cic_enable, cic_strobe_in, cic_strobe_out}); end
        n_cmp++; if (cic_rate !== 8'd2) begin n_err++; $display("FAIL rc_rate: got %0d want 2", cic_rate); end
        cyc();
        n_cmp++; if (cic_enable !== 1'b0) begin n_err++; $display("FAIL rc_flush2: got enable %b want 0", cic_enable); end
        cyc();
        n_cmp++; if (cic_enable !== 1'b1) begin n_err++; $display("FAIL rc_prime: got enable %b want 1", cic_enable); end
        cyc();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 16'h0410 + 16'(i));
            n_cmp++; if ({last_ready, cic_strobe_in} !== {2{(i % 2) == 0}}) begin n_err++; $display("FAIL rc_tick[%0d]: got rdy/si %b want %b", i, {last_ready, cic_strobe_in}, {2{(i % 2) == 0}}); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        start_run(8'd4);
        repeat (4) tick(1'b1, 16'h0501);
        out_tick = 1'b1;
        #1;
        n_cmp++; if ({in_tready, cic_strobe_out, cic_enable} !== 3'b111) begin n_err++; $display("FAIL ar_pre: got rdy/so/en %b want 111", {in_tready, cic_strobe_out, cic_enable}); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({cic_enable, cic_strobe_in, cic_strobe_out, in_tready, underrun} !== 5'b0) begin n_err++; $display("FAIL ar_flags: got %b want 00000", {cic_enable, cic_strobe_in, cic_strobe_out, in_tready, underrun}); end
        n_cmp++; if ({cic_rate, cic_data} !== {8'd1, 16'h0000}) begin n_err++; $display("FAIL ar_rate_data: got %0d/%h want 1/0000", cic_rate, cic_data); end
        out_tick = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        n_cmp++; if ({cic_enable, cic_strobe_in, cic_strobe_out} !== 3'b000) begin n_err++; $display("FAIL ar_after: got en/si/so %b want 000", {cic_enable, cic_strobe_in, cic_strobe_out}); end
        run = 1'b0;
    endtask

    task automatic test_stop();
        apply_reset();
        rate_in   = 8'd4;
        rate_set  = 1'b1;
        run       = 1'b1;
        in_tvalid = 1'b0;
        cyc();
        rate_set = 1'b0;
        repeat (3) cyc();
        n_cmp++; if (cic_enable !== 1'b1) begin n_err++; $display("FAIL stop_prime_held: got enable %b want 1", cic_enable); end
        run = 1'b0;
        cyc();
        n_cmp++; if (cic_enable !== 1'b0) begin n_err++; $display("FAIL stop_from_prime: got enable %b want 0", cic_enable); end
        tick(1'b1, 16'h0601);
        cyc();
        n_cmp++; if ({last_ready, cic_strobe_out, cic_data} !== {2'b00, 16'h0000}) begin n_err++; $display("FAIL stop_idle_tick: got rdy/so %b data %h want 00 data 0000", {last_ready, cic_strobe_out}, cic_data); end
        start_run(8'd4);
        tick(1'b1, 16'h0611);
        n_cmp++; if ({last_ready, cic_data} !== {1'b1, 16'h0611}) begin n_err++; $display("FAIL stop_run_pop: got rdy %b data %h want 1 0611", last_ready, cic_data); end
        tick(1'b1, 16'h0612);
        run = 1'b0;
        cyc();
        n_cmp++; if (cic_enable !== 1'b0) begin n_err++; $display("FAIL stop_from_run: got enable %b want 0", cic_enable); end
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 16'h06FF);
            n_cmp++; if ({last_ready, cic_strobe_out, cic_strobe_in} !== 3'b000) begin n_err++; $display("FAIL stop_no_pop[%0d]: got rdy/so/si %b want 000", i, {last_ready, cic_strobe_out, cic_strobe_in}); end
        end
        n_cmp++; if (cic_data !== 16'h0611) begin n_err++; $display("FAIL stop_data_held: got %h want 0611", cic_data); end
    endtask

    initial begin
        test_reset();
        test_rate4_stream();
        test_rate_clamp();
        test_underrun();
        test_rate_change();
        test_async_reset();
        test_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
